dmem_ctrl: RTL

- Data-memory controller directly downstream of the CPU memory stage.
- Consumes the M-stage request (address, store data, 3-bit memop, write enable) and owns a word-wide synchronous RAM.
- Performs byte/halfword lane alignment and load sign/zero extension; returns load data one cycle after acceptance.
- Sub-word stores use a read-modify-write FSM, so the block exposes a ready handshake the pipeline stalls on.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: memop encodings, FSM states, lane indices.
package dmem_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StRmwRd,
        StRmwWr
    } dmem_state_e;

    // Unused encodings, and unsigned ops on stores, have no meaning.
    function automatic logic memop_illegal(input logic [2:0] op, input logic we);
        return (op == 3'b011) || (op[2:1] == 2'b11) || (we && op[2]);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load byte/half extract with extension, store merge with byte mask.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_lane,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [31:0] st_wdata,
    input  logic [2:0]  st_op,
    input  logic [1:0]  st_lane,
    output logic [31:0] st_merged,
    output logic [3:0]  st_be
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] st_aligned;

    always_comb begin
        ld_byte = ld_word[7:0];
        unique case (ld_lane)
            LANE_0: ld_byte = ld_word[7:0];
            LANE_1: ld_byte = ld_word[15:8];
            LANE_2: ld_byte = ld_word[23:16];
            LANE_3: ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_op)
            MEMOP_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEMOP_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            MEMOP_BU: ld_data = {24'h0, ld_byte};
            MEMOP_HU: ld_data = {16'h0, ld_half};
            default:  ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_aligned = st_wdata;
        st_be      = 4'hf;
        case (st_op)
            MEMOP_B: begin
                st_aligned = {4{st_wdata[7:0]}};
                st_be      = 4'b0001 << st_lane;
            end
            MEMOP_H: begin
                st_aligned = {2{st_wdata[15:0]}};
                st_be      = st_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        st_merged = st_old;
        for (int i = 0; i < 4; i++) begin
            if (st_be[i]) st_merged[8*i +: 8] = st_aligned[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller with lane alignment and sub-word read-modify-write.
// Define DMEM_CTRL_BE_EN for a byte-enabled RAM with single-cycle sub-word stores.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned AW          = 14
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] req_word;
    logic          req_err;
    logic          accept;

    logic          ram_we, ram_re;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_be;
    logic [31:0]   rd_word_q;

    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_load_q, rsp_load_d;
    logic [2:0]    rsp_op_q;
    logic [1:0]    rsp_lane_q;

    logic [31:0]   ld_data, st_old, st_wdata, st_merged;
    logic [2:0]    st_op;
    logic [1:0]    st_lane;
    logic [3:0]    st_be;

    assign req_word = req_addr[AW+1:2];

    always_comb begin
        req_err = memop_illegal(req_op, req_we)
                | (((req_op == MEMOP_H) || (req_op == MEMOP_HU)) && req_addr[0])
                | ((req_op == MEMOP_W) && (req_addr[1:0] != 2'b00))
                | (|(req_addr >> (AW + 2)));
    end

`ifdef DMEM_CTRL_BE_EN
    assign req_ready = ~clr;
    assign st_old    = 32'h0;
    assign st_wdata  = req_wdata;
    assign st_op     = req_op;
    assign st_lane   = req_addr[1:0];
`else
    dmem_state_e   state_q, state_d;
    logic          rmw_start;
    logic [AW-1:0] rmw_addr_q;
    logic [2:0]    rmw_op_q;
    logic [1:0]    rmw_lane_q;
    logic [31:0]   rmw_wdata_q;
    logic [31:0]   merged_q;

    assign req_ready = (state_q == StIdle);
    assign st_old    = rd_word_q;
    assign st_wdata  = rmw_wdata_q;
    assign st_op     = rmw_op_q;
    assign st_lane   = rmw_lane_q;
`endif

    assign accept = req_valid && req_ready;

    always_comb begin
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_waddr   = req_word;
        ram_raddr   = req_word;
        ram_wdata   = req_wdata;
        ram_be      = 4'hf;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_load_d  = 1'b0;
`ifndef DMEM_CTRL_BE_EN
        state_d     = state_q;
        rmw_start   = 1'b0;
`endif
        if (accept) begin
            rsp_valid_d = 1'b1;
            if (req_err) begin
                rsp_err_d = 1'b1;
            end else if (!req_we) begin
                ram_re     = 1'b1;
                rsp_load_d = 1'b1;
            end else if (req_op == MEMOP_W) begin
                ram_we = 1'b1;
            end else begin
`ifdef DMEM_CTRL_BE_EN
                ram_we    = 1'b1;
                ram_wdata = st_merged;
                ram_be    = st_be;
`else
                rsp_valid_d = 1'b0;
                ram_re      = 1'b1;
                rmw_start   = 1'b1;
                state_d     = StRmwRd;
`endif
            end
        end
`ifndef DMEM_CTRL_BE_EN
        case (state_q)
            StRmwRd: state_d = StRmwWr;
            StRmwWr: begin
                ram_we      = 1'b1;
                ram_waddr   = rmw_addr_q;
                ram_wdata   = merged_q;
                ram_be      = st_be;
                rsp_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: ;
        endcase
`endif
        // Reset wins over any write scheduled for this edge, aborting an RMW.
        if (clr) ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) mem[ram_waddr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        if (ram_re) rd_word_q <= mem[ram_raddr];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
`ifndef DMEM_CTRL_BE_EN
            state_q     <= StIdle;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
`ifndef DMEM_CTRL_BE_EN
            state_q     <= state_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rsp_op_q   <= req_op;
            rsp_lane_q <= req_addr[1:0];
        end
`ifndef DMEM_CTRL_BE_EN
        if (rmw_start) begin
            rmw_addr_q  <= req_word;
            rmw_op_q    <= req_op;
            rmw_lane_q  <= req_addr[1:0];
            rmw_wdata_q <= req_wdata;
        end
        if (state_q == StRmwRd) merged_q <= st_merged;
`endif
    end

    dmem_lane_align u_align (
        .ld_word   (rd_word_q),
        .ld_op     (rsp_op_q),
        .ld_lane   (rsp_lane_q),
        .ld_data   (ld_data),
        .st_old    (st_old),
        .st_wdata  (st_wdata),
        .st_op     (st_op),
        .st_lane   (st_lane),
        .st_merged (st_merged),
        .st_be     (st_be)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_load_q ? ld_data : 32'h0;

endmodule
